mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction cache and the data cache and the shared RAM. It accepts independent icache (read-only) and dcache (read/write) requests, grants exactly one at a time via a registered grant FSM, forwards the granted request to RAM, and returns load data and a wait/ready indication to the winner. It sits directly downstream of the icache/dcache pair and upstream of the RAM model.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-side types used by the memory arbiter and its neighbours.
//   word_t      : 32-bit machine word (addresses and data)
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : grant state of the memory arbiter
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Single-port arbiter between the icache (read-only), the dcache (read/write)
// and the shared RAM. One requester is granted at a time by a registered FSM;
// the granted request is forwarded to RAM and the winner sees wait low for the
// single cycle in which RAM reports ACCESS.
//
// Ports:
//   CLK, nRST                  clock (rising edge), synchronous active-low reset
//   iREN, iaddr                icache read request and word address
//   iwait, iload               icache wait (low = completing cycle) and data
//   dREN, dWEN, daddr, dstore  dcache read/write request, address, write data
//   dwait, dload               dcache wait (low = completing cycle) and data
//   ramREN, ramWEN             RAM read / write strobes
//   ramaddr, ramstore          RAM address and write data
//   ramload, ramstate          RAM read data and status
//
// Parameter:
//   FAIR_LIMIT  consecutive data grants allowed while an instruction request
//               waits (only meaningful with ARB_FAIR_EN)
//
// Build option:
//   ARB_FAIR_EN  defined   -> bounded data priority via a saturating counter
//                undefined -> strict data priority (icache may starve)
// -----------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  logic       w_dReq;
  logic       w_access;
  logic       w_fairForceI;

  assign w_dReq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
  localparam logic [2:0] FairLimitCnt = 3'(FAIR_LIMIT);
  logic [2:0] r_fairCnt;

  // Once the data side has won FAIR_LIMIT times in a row against a waiting
  // icache request, the next collision goes to the icache instead.
  assign w_fairForceI = iREN && (r_fairCnt == FairLimitCnt);

  // Counter advances only on data grants that beat a pending instruction
  // request, saturates at 7, and clears whenever the icache is granted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_fairCnt <= 3'd0;
    end else if (r_state == IDLE) begin
      if (w_nextState == DGRANT && iREN && r_fairCnt != 3'd7) begin
        r_fairCnt <= r_fairCnt + 3'd1;
      end else if (w_nextState == IGRANT) begin
        r_fairCnt <= 3'd0;
      end
    end
  end
`else
  assign w_fairForceI = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. Outputs depend only on the current grant
  // and live inputs, so a dropped request removes its strobes in the same
  // cycle and a completing ACCESS lowers wait in the same cycle. Wait is
  // gated by the request so an abort never produces a wait-low pulse.
  always_comb begin
    w_nextState = r_state;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (r_state)
      IDLE: begin
        if (w_dReq && !w_fairForceI) begin
          w_nextState = DGRANT;
        end else if (iREN) begin
          w_nextState = IGRANT;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~(w_access & w_dReq);
        if (w_access || !w_dReq) begin
          w_nextState = IDLE;
        end
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~(w_access & iREN);
        if (w_access || !iREN) begin
          w_nextState = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a per-cycle vector table covering
// reset, icache read, collision, write, error hold, aborts and reset during a
// transaction, followed by a multi-round fairness sequence.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.FAIR_LIMIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic      nRst;
    logic      iRen;
    word_t     iAddr;
    logic      dRen;
    logic      dWen;
    word_t     dAddr;
    word_t     dStore;
    ramstate_t ramState;
    word_t     ramLoad;
    logic      expIwait;
    logic      expDwait;
    word_t     expIload;
    word_t     expDload;
    logic      expRen;
    logic      expWen;
    word_t     expAddr;
    word_t     expStore;
  } vec_t;

  localparam int NumVecs = 29;
  vec_t vecs [NumVecs];

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL row%0d %s: got %h expected %h", row, name, actual, expected);
    end
  endtask

  // Drive one vector's inputs
  task automatic applyStimulus(input vec_t v);
    nRST     = v.nRst;
    iREN     = v.iRen;
    iaddr    = v.iAddr;
    dREN     = v.dRen;
    dWEN     = v.dWen;
    daddr    = v.dAddr;
    dstore   = v.dStore;
    ramstate = v.ramState;
    ramload  = v.ramLoad;
  endtask

  initial begin
    // Columns: nRst iRen iAddr dRen dWen dAddr dStore ramState ramLoad |
    //          iwait dwait iload dload ramREN ramWEN ramaddr ramstore
    // Reset held with both requests active
    vecs[0]  = '{0,1,32'h40,1,0,32'h100,0,FREE,0,            1,1,0,0,0,0,0,0};
    vecs[1]  = '{0,1,32'h40,1,0,32'h100,0,FREE,0,            1,1,0,0,0,0,0,0};
    // Icache read, ACCESS two cycles after grant
    vecs[2]  = '{1,1,32'h40,0,0,0,0,FREE,0,                  1,1,0,0,0,0,0,0};
    vecs[3]  = '{1,1,32'h40,0,0,0,0,BUSY,32'hDEADBEEF,       1,1,32'hDEADBEEF,0,1,0,32'h40,0};
    vecs[4]  = '{1,1,32'h40,0,0,0,0,BUSY,32'hDEADBEEF,       1,1,32'hDEADBEEF,0,1,0,32'h40,0};
    vecs[5]  = '{1,1,32'h40,0,0,0,0,ACCESS,32'hDEADBEEF,     0,1,32'hDEADBEEF,0,1,0,32'h40,0};
    vecs[6]  = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};
    // Collision: data first, then instruction with zero-latency RAM
    vecs[7]  = '{1,1,32'h44,1,0,32'h100,32'hAAAA5555,FREE,0, 1,1,0,0,0,0,0,0};
    vecs[8]  = '{1,1,32'h44,1,0,32'h100,32'hAAAA5555,BUSY,32'hCAFEF00D,
                 1,1,0,32'hCAFEF00D,1,0,32'h100,32'hAAAA5555};
    vecs[9]  = '{1,1,32'h44,1,0,32'h100,32'hAAAA5555,ACCESS,32'hCAFEF00D,
                 1,0,0,32'hCAFEF00D,1,0,32'h100,32'hAAAA5555};
    vecs[10] = '{1,1,32'h44,0,0,0,0,FREE,0,                  1,1,0,0,0,0,0,0};
    vecs[11] = '{1,1,32'h44,0,0,0,0,ACCESS,32'h11112222,     0,1,32'h11112222,0,1,0,32'h44,0};
    vecs[12] = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};
    // Write with both dREN and dWEN: write wins
    vecs[13] = '{1,0,0,1,1,32'h200,32'h12345678,FREE,0,      1,1,0,0,0,0,0,0};
    vecs[14] = '{1,0,0,1,1,32'h200,32'h12345678,BUSY,0,      1,1,0,0,0,1,32'h200,32'h12345678};
    vecs[15] = '{1,0,0,1,1,32'h200,32'h12345678,ACCESS,0,    1,0,0,0,0,1,32'h200,32'h12345678};
    vecs[16] = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};
    // ERROR holds the grant, then icache abort
    vecs[17] = '{1,1,32'h80,0,0,0,0,FREE,0,                  1,1,0,0,0,0,0,0};
    vecs[18] = '{1,1,32'h80,0,0,0,0,ERROR,32'h5,             1,1,32'h5,0,1,0,32'h80,0};
    vecs[19] = '{1,1,32'h80,0,0,0,0,ERROR,32'h5,             1,1,32'h5,0,1,0,32'h80,0};
    vecs[20] = '{1,1,32'h80,0,0,0,0,ERROR,32'h5,             1,1,32'h5,0,1,0,32'h80,0};
    vecs[21] = '{1,0,32'h80,0,0,0,0,ERROR,32'h5,             1,1,32'h5,0,0,0,32'h80,0};
    vecs[22] = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};
    // Dcache abort coinciding with ACCESS: no dwait pulse
    vecs[23] = '{1,0,0,1,0,32'h300,0,FREE,0,                 1,1,0,0,0,0,0,0};
    vecs[24] = '{1,0,0,0,0,32'h300,0,ACCESS,32'h77,          1,1,0,32'h77,0,0,32'h300,0};
    vecs[25] = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};
    // Reset in the middle of an icache grant
    vecs[26] = '{1,1,32'h90,0,0,0,0,FREE,0,                  1,1,0,0,0,0,0,0};
    vecs[27] = '{0,1,32'h90,0,0,0,0,BUSY,0,                  1,1,0,0,1,0,32'h90,0};
    vecs[28] = '{1,0,0,0,0,0,0,FREE,0,                       1,1,0,0,0,0,0,0};

    // Initial reset edge so the state register is defined
    applyStimulus(vecs[0]);
    @(posedge CLK);

    for (int i = 0; i < NumVecs; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("iwait",    i, {31'b0, iwait},  {31'b0, vecs[i].expIwait});
      checkOutput("dwait",    i, {31'b0, dwait},  {31'b0, vecs[i].expDwait});
      checkOutput("iload",    i, iload,           vecs[i].expIload);
      checkOutput("dload",    i, dload,           vecs[i].expDload);
      checkOutput("ramREN",   i, {31'b0, ramREN}, {31'b0, vecs[i].expRen});
      checkOutput("ramWEN",   i, {31'b0, ramWEN}, {31'b0, vecs[i].expWen});
      checkOutput("ramaddr",  i, ramaddr,         vecs[i].expAddr);
      checkOutput("ramstore", i, ramstore,        vecs[i].expStore);
    end

    // Fairness: both requesters keep asking every arbitration round.
    @(negedge CLK);
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE; ramload = '0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int r = 0; r < 10; r++) begin
      logic expI;
`ifdef ARB_FAIR_EN
      expI = ((r % 5) == 4);
`else
      expI = 1'b0;
`endif
      // Arbitration cycle (IDLE)
      iREN = 1'b1; iaddr = 32'h400;
      dREN = 1'b1; daddr = 32'h500; dstore = '0;
      ramstate = FREE;
      @(posedge CLK);
      // Grant cycle with immediate ACCESS
      @(negedge CLK);
      ramstate = ACCESS;
      #1;
      checkOutput("fair_iwait", 100 + r, {31'b0, iwait}, {31'b0, ~expI});
      checkOutput("fair_dwait", 100 + r, {31'b0, dwait}, {31'b0, expI});
      checkOutput("fair_addr",  100 + r, ramaddr, expI ? 32'h400 : 32'h500);
      @(posedge CLK);
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
